fir_coef_loader: RTL
====================

Name: fir_coef_loader

Overview:
- Configuration controller for fir_filter_transposed_pipelined.
- Receives a serial coefficient frame on the same one-bit valid-qualified link style as the sample path, validates it, and writes coefficients into the filter's shadow coefficient bank.
- Issues a single commit pulse only when the whole frame passes its checksum, so the filter never runs with a partial coefficient set.
- Sits beside the deserializer/FIR/serializer chain in top_level and shares i_clk, i_rst and i_en with it.

Parameters:
- DATA_WIDTH, 24, coefficient word width and serial word length.
- FIR_DEPTH, 16, number of coefficient taps; range 1..256.
- ADDR_WIDTH, $clog2(FIR_DEPTH) (minimum 1), coefficient address width.
- TIMEOUT_CYCLES, 1024, idle-bit limit for the optional timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_en  in  1  global enable; when low, all state holds and no strobes are issued.
- i_sof  in  1  start-of-frame pulse; realigns the bit counter and restarts the FSM.
- i_din  in  1  serial data, MSB first.
- i_din_valid  in  1  i_din is sampled this cycle.
- ov_coef_addr  out  ADDR_WIDTH  shadow-bank write address.
- ov_coef_data  out  DATA_WIDTH  shadow-bank write data.
- o_coef_we  out  1  one-cycle shadow write strobe.
- o_commit  out  1  one-cycle pulse: copy shadow bank to the active bank.
- o_busy  out  1  a frame is in progress.
- o_error  out  1  sticky error flag.
- ov_err_code  out  2  0 none, 1 bad header, 2 checksum mismatch, 3 aborted.

Behaviour:
- Reset: all outputs are 0. FSM is IDLE. Bit count, word count and checksum accumulator are 0.
- Gating: all activity, including i_sof, requires i_en=1. A bit is consumed only when i_en and i_din_valid are both 1.
- Frame format: header word, then N coefficient words, then one checksum word. Every word is DATA_WIDTH bits.
- Header fields:
  - bits [DW-1:DW-8]: magic 8'hA5.
  - bits [15:8]: N.
  - bits [7:0]: start address S.
- Header is valid only if magic is correct, N≥1 and S+N≤FIR_DEPTH.
- A word completes on the cycle its DATA_WIDTH-th bit is consumed. Its result (strobe, state change or flag) registers on the next clock edge, i.e. latency 1.
- FSM states: IDLE, HEADER, LOAD, CHECK.
  - IDLE: bits are ignored. i_sof → HEADER.
  - HEADER: on word complete, a valid header → LOAD, latching N and S and clearing o_error/ov_err_code. An invalid header → IDLE with o_error=1, code 1.
  - LOAD: each complete word produces o_coef_we=1, ov_coef_addr=S+k, ov_coef_data=word, and is added to the accumulator modulo 2^DATA_WIDTH. After word N-1 → CHECK.
  - CHECK: on word complete, if word equals the accumulator, o_commit=1 for one cycle; otherwise o_error=1, code 2. Either way → IDLE.
- o_busy=1 in HEADER, LOAD and CHECK.
- ov_coef_addr and ov_coef_data hold their last values between strobes.
- o_commit and o_coef_we are never asserted in the same cycle.
- i_sof while in HEADER, LOAD or CHECK: the current frame is aborted with no commit, o_error=1, code 3, and the FSM goes to HEADER. The bit counter clears. If i_din_valid is high in the same cycle, that bit counts as bit 0 of the new header.
- i_sof in the cycle a word completes takes priority: the completed word is discarded.
- Reset asserted mid-frame: the frame is discarded immediately; no commit is issued.

Optional Feature:
- Macro: FIR_COEF_LOADER_TIMEOUT_EN.
- Defined: a counter clears on every consumed bit and on i_sof, and increments in any non-IDLE state while i_en=1. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE with o_error=1, code 3, and no commit.
- Undefined: no counter is built. The FSM waits indefinitely for bits.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_LOAD_MAGIC=8'hA5.
  - Error-code constants ERR_NONE, ERR_HDR, ERR_CSUM, ERR_ABORT.
  - The state encoding.
- Sub-module: reuse the existing deserializer (LENGTH=DATA_WIDTH) as the word assembler, with its bit counter cleared by i_sof.
- The controller FSM, address counter and accumulator live in fir_coef_loader.

Test Plan:
- Nominal load: sof; header 24'hA51000; 16 words 1..16; checksum 136 → 16 strobes at addr 0..15 with data 1..16, then one o_commit; o_error=0.
- Partial load: header 24'hA5040C; words 24'hFFFFFF×4; checksum 24'hFFFFFC → writes to addr 12..15, commit.
- Bad header: 24'hA51101 (S+N=18>16) → no strobes, o_error=1, code 1, o_busy=0.
- Checksum failure: valid 2-word frame of 5 and 7 with checksum 13 → 2 strobes, no commit, code 2. A following correct frame clears o_error and commits.
- Abort: sof mid-LOAD after 3 words, then a full valid frame → code 3 latched, then cleared at the new header, and exactly one commit.
- Gating and timeout: hold i_en=0 for 50 cycles mid-word → no state change. With FIR_COEF_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=64, stall valid for 64 cycles → IDLE, code 3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: header magic, error codes
// and the loader FSM state encoding.
package fir_pkg;

    localparam logic [7:0] FIR_LOAD_MAGIC = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_CHECK
    } load_state_t;

endpackage

// File: rtl/fir_coef_loader_deserializer.sv
// Serial-to-parallel word assembler, MSB first; done flags the cycle the last
// bit of a word is consumed, with the assembled word presented alongside.
module deserializer #(
    parameter int LENGTH = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              din,
    input  logic              din_valid,
    output logic [LENGTH-1:0] word,
    output logic              done
);

    localparam int CW = (LENGTH > 2) ? $clog2(LENGTH) : 1;

    logic [LENGTH-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic              take;

    assign take = en & din_valid;
    assign word = {shreg[LENGTH-2:0], din};
    assign done = take & ~clr & (cnt == CW'(LENGTH - 1));

    // clr realigns the count; a bit arriving with clr is bit 0 of the new word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (en) begin
            if (take)
                shreg <= word;
            if (clr)
                cnt <= take ? CW'(1) : '0;
            else if (take)
                cnt <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient frame loader: header, N coefficient words, checksum; writes the
// shadow bank and commits only a fully verified frame.
// Optional idle timeout enabled by defining FIR_COEF_LOADER_TIMEOUT_EN.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int FIR_DEPTH      = 16,
    parameter int ADDR_WIDTH     = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_sof,
    input  logic                  i_din,
    input  logic                  i_din_valid,
    output logic [ADDR_WIDTH-1:0] ov_coef_addr,
    output logic [DATA_WIDTH-1:0] ov_coef_data,
    output logic                  o_coef_we,
    output logic                  o_commit,
    output logic                  o_busy,
    output logic                  o_error,
    output logic [1:0]            ov_err_code
);

    if (FIR_DEPTH < 1 || FIR_DEPTH > 256 || DATA_WIDTH < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fir_coef_loader: unsupported parameter set");
    end

    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;

    deserializer #(.LENGTH(DATA_WIDTH)) u_deser (
        .clk       (i_clk),
        .rst       (i_rst),
        .en        (i_en),
        .clr       (i_sof),
        .din       (i_din),
        .din_valid (i_din_valid),
        .word      (word),
        .done      (word_done)
    );

    load_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [7:0]            remaining, remaining_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  we_nxt, commit_nxt, error_nxt;
    logic [1:0]            code_nxt;
    logic                  timeout_hit;

    logic [7:0] hdr_n, hdr_s;
    logic       hdr_ok;

    assign hdr_n  = word[15:8];
    assign hdr_s  = word[7:0];
    assign hdr_ok = (word[DATA_WIDTH-1 -: 8] == FIR_LOAD_MAGIC) && (hdr_n != 8'd0) &&
                    (({1'b0, hdr_s} + {1'b0, hdr_n}) <= 9'(FIR_DEPTH));

`ifdef FIR_COEF_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            to_cnt <= '0;
        else if (i_en) begin
            if (state == ST_IDLE || i_sof || i_din_valid)
                to_cnt <= '0;
            else if (!timeout_hit)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        acc_nxt       = acc;
        addr_nxt      = ov_coef_addr;
        data_nxt      = ov_coef_data;
        we_nxt        = 1'b0;
        commit_nxt    = 1'b0;
        error_nxt     = o_error;
        code_nxt      = ov_err_code;
        if (i_en) begin
            // sof outranks a word completing in the same cycle
            if (i_sof) begin
                if (state != ST_IDLE) begin
                    error_nxt = 1'b1;
                    code_nxt  = ERR_ABORT;
                end
                state_nxt = ST_HEADER;
            end else if (timeout_hit && !i_din_valid) begin
                state_nxt = ST_IDLE;
                error_nxt = 1'b1;
                code_nxt  = ERR_ABORT;
            end else if (word_done) begin
                case (state)
                    ST_HEADER: begin
                        if (hdr_ok) begin
                            state_nxt     = ST_LOAD;
                            ptr_nxt       = hdr_s[ADDR_WIDTH-1:0];
                            remaining_nxt = hdr_n;
                            acc_nxt       = '0;
                            error_nxt     = 1'b0;
                            code_nxt      = ERR_NONE;
                        end else begin
                            state_nxt = ST_IDLE;
                            error_nxt = 1'b1;
                            code_nxt  = ERR_HDR;
                        end
                    end
                    ST_LOAD: begin
                        we_nxt        = 1'b1;
                        addr_nxt      = ptr;
                        data_nxt      = word;
                        acc_nxt       = acc + word;
                        ptr_nxt       = ptr + ADDR_WIDTH'(1);
                        remaining_nxt = remaining - 8'd1;
                        if (remaining == 8'd1)
                            state_nxt = ST_CHECK;
                    end
                    ST_CHECK: begin
                        state_nxt = ST_IDLE;
                        if (word == acc)
                            commit_nxt = 1'b1;
                        else begin
                            error_nxt = 1'b1;
                            code_nxt  = ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr          <= '0;
            remaining    <= '0;
            acc          <= '0;
            ov_coef_addr <= '0;
            ov_coef_data <= '0;
            o_coef_we    <= 1'b0;
            o_commit     <= 1'b0;
            o_error      <= 1'b0;
            ov_err_code  <= ERR_NONE;
        end else begin
            ptr          <= ptr_nxt;
            remaining    <= remaining_nxt;
            acc          <= acc_nxt;
            ov_coef_addr <= addr_nxt;
            ov_coef_data <= data_nxt;
            o_coef_we    <= we_nxt;
            o_commit     <= commit_nxt;
            o_error      <= error_nxt;
            ov_err_code  <= code_nxt;
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule
